// File: rtl/sram_port_arbiter.sv
// Two-port round-robin controller for an asynchronous 8-bit SRAM.
// Registered strobes are derived from the next state so each takes its value in the state it belongs to.
`timescale 1ns/1ps
module sram_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int WR_PULSE = 2,
  parameter int RD_WAIT  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          sram_cs_b,
  output logic          sram_we_b,
  output logic          sram_oe_b,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_io_out,
  output logic          sram_io_oe,
  input  logic [DW-1:0] sram_io_in
);

  localparam int MAXP = (WR_PULSE > RD_WAIT) ? WR_PULSE : RD_WAIT;
  localparam int CW   = $clog2(MAXP + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] WR_LOW  = 3'd2;
  localparam logic [2:0] WR_HOLD = 3'd3;
  localparam logic [2:0] RD_LOW  = 3'd4;
  localparam logic [2:0] RD_END  = 3'd5;

  logic [2:0]    state, nxt;
  logic [CW-1:0] cnt;
  logic          cnt_zero;
  logic          op_we, op_port, last;
  logic          grant0, grant1, acc0, acc1, accept, nxt_we;

  // last=1 means port 1 was granted last, so port 0 is preferred after reset
  assign grant0     = req0_valid & (~req1_valid | last);
  assign grant1     = req1_valid & (~req0_valid | ~last);
  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;
  assign accept     = acc0 | acc1;
  assign nxt_we     = accept ? (acc1 ? req1_we : req0_we) : op_we;
  assign cnt_zero   = (cnt == '0);
  assign busy       = (state != IDLE);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = SETUP;
      SETUP:   nxt = op_we ? WR_LOW : RD_LOW;
      WR_LOW:  if (cnt_zero) nxt = WR_HOLD;
      WR_HOLD: nxt = IDLE;
      RD_LOW:  if (cnt_zero) nxt = RD_END;
      RD_END:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_we       <= 1'b0;
      op_port     <= 1'b0;
      last        <= 1'b1;
      sram_cs_b   <= 1'b1;
      sram_we_b   <= 1'b1;
      sram_oe_b   <= 1'b1;
      sram_io_oe  <= 1'b0;
      sram_addr   <= '0;
      sram_io_out <= '0;
      rdata       <= '0;
      done0       <= 1'b0;
      done1       <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        op_we     <= nxt_we;
        op_port   <= acc1;
        last      <= acc1;
        sram_addr <= acc1 ? req1_addr : req0_addr;
        if (nxt_we) sram_io_out <= acc1 ? req1_wdata : req0_wdata;
      end
      if (state == SETUP)
        cnt <= op_we ? CW'(WR_PULSE - 1) : CW'(RD_WAIT - 1);
      else if ((state == WR_LOW || state == RD_LOW) && !cnt_zero)
        cnt <= cnt - CW'(1);
      if (state == RD_LOW && cnt_zero) rdata <= sram_io_in;
      // IO is driven only for writes, and never during RD_LOW
      sram_cs_b  <= (nxt == IDLE);
      sram_we_b  <= (nxt != WR_LOW);
      sram_oe_b  <= (nxt != RD_LOW);
      sram_io_oe <= ((nxt == SETUP) & nxt_we) | (nxt == WR_LOW) | (nxt == WR_HOLD);
      done0      <= ((nxt == WR_HOLD) | (nxt == RD_END)) & ~op_port;
      done1      <= ((nxt == WR_HOLD) | (nxt == RD_END)) & op_port;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: default instance plus a WR_PULSE=1/RD_WAIT=4 instance, each with an SRAM model.
`timescale 1ns/1ps
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       v0 = 1'b0, we0 = 1'b0, v1 = 1'b0, we1 = 1'b0;
  logic [7:0] a0 = '0, d0 = '0, a1 = '0, d1 = '0;
  logic       use6 = 1'b0;

  logic       ra0, ra1, da0, da1, busya, csa, wea, oea, ioea;
  logic [7:0] rda, addra, ioa, ina;
  logic       rb0, rb1, db0, db1, busyb, csb, web, oeb, ioeb;
  logic [7:0] rdb, addrb, iob, inb;

  int total = 0;
  int bad   = 0;

  sram_port_arbiter u_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(ra0), .req0_we(we0), .req0_addr(a0), .req0_wdata(d0),
    .req1_valid(v1), .req1_ready(ra1), .req1_we(we1), .req1_addr(a1), .req1_wdata(d1),
    .done0(da0), .done1(da1), .rdata(rda), .busy(busya),
    .sram_cs_b(csa), .sram_we_b(wea), .sram_oe_b(oea), .sram_addr(addra),
    .sram_io_out(ioa), .sram_io_oe(ioea), .sram_io_in(ina)
  );

  sram_port_arbiter #(.WR_PULSE(1), .RD_WAIT(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(rb0), .req0_we(we0), .req0_addr(a0), .req0_wdata(d0),
    .req1_valid(v1), .req1_ready(rb1), .req1_we(we1), .req1_addr(a1), .req1_wdata(d1),
    .done0(db0), .done1(db1), .rdata(rdb), .busy(busyb),
    .sram_cs_b(csb), .sram_we_b(web), .sram_oe_b(oeb), .sram_addr(addrb),
    .sram_io_out(iob), .sram_io_oe(ioeb), .sram_io_in(inb)
  );

  // Asynchronous SRAM models: write commits on the rising edge of we_b while selected
  logic [7:0] mema [256];
  logic [7:0] memb [256];
  always @(posedge wea) if (csa === 1'b0) mema[addra] <= (ioea === 1'b1) ? ioa : 8'hxx;
  always @(posedge web) if (csb === 1'b0) memb[addrb] <= (ioeb === 1'b1) ? iob : 8'hxx;
  assign ina = (csa === 1'b0 && oea === 1'b0) ? mema[addra] : 8'h00;
  assign inb = (csb === 1'b0 && oeb === 1'b0) ? memb[addrb] : 8'h00;

  logic       m_ready0, m_ready1, m_done0, m_done1, m_we, m_oe;
  logic [7:0] m_rdata;
  assign m_ready0 = use6 ? rb0 : ra0;
  assign m_ready1 = use6 ? rb1 : ra1;
  assign m_done0  = use6 ? db0 : da0;
  assign m_done1  = use6 ? db1 : da1;
  assign m_we     = use6 ? web : wea;
  assign m_oe     = use6 ? oeb : oea;
  assign m_rdata  = use6 ? rdb : rda;

  logic grants [8];
  logic dones  [8];
  int   ng, nd;

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One access on port p; lat = negedges from accept to done (-1 on timeout)
  task automatic do_access(input logic p, input logic w, input logic [7:0] a, input logic [7:0] d,
                           output int lat, output logic [7:0] rd, output int wlow,
                           output int olow, output int aw);
    logic got;
    @(negedge clk);
    if (!p) begin v0 = 1'b1; we0 = w; a0 = a; d0 = d; end
    else    begin v1 = 1'b1; we1 = w; a1 = a; d1 = d; end
    #1;
    aw = 0;
    while (!(p ? m_ready1 : m_ready0) && aw < 50) begin
      @(negedge clk); #1; aw++;
    end
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    #1;
    lat = 1; wlow = 0; olow = 0; got = 1'b0;
    while (!got && lat < 50) begin
      if (!m_we) wlow++;
      if (!m_oe) olow++;
      if (p ? m_done1 : m_done0) got = 1'b1;
      else begin @(negedge clk); #1; lat++; end
    end
    rd = m_rdata;
    if (!got) lat = -1;
  endtask

  // Both ports issue writes; records grant order and done order
  task automatic run_pair(input int n0, input int n1, input logic [7:0] ab0, input logic [7:0] db0_,
                          input logic [7:0] ab1, input logic [7:0] db1_);
    int g0 = 0, g1 = 0;
    ng = 0; nd = 0;
    for (int k = 0; k < 200 && nd < n0 + n1; k++) begin
      @(negedge clk);
      v0 = (g0 < n0); we0 = 1'b1; a0 = ab0 + 8'(g0); d0 = db0_ + 8'(g0);
      v1 = (g1 < n1); we1 = 1'b1; a1 = ab1 + 8'(g1); d1 = db1_ + 8'(g1);
      #1;
      if (m_done0 && nd < 8) begin dones[nd] = 1'b0; nd++; end
      if (m_done1 && nd < 8) begin dones[nd] = 1'b1; nd++; end
      if (v0 && m_ready0 && ng < 8) begin grants[ng] = 1'b0; ng++; g0++; end
      if (v1 && m_ready1 && ng < 8) begin grants[ng] = 1'b1; ng++; g1++; end
    end
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({csa, wea, oea, ioea, busya, da0, da1} !== 7'b1110000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 1110000", {csa, wea, oea, ioea, busya, da0, da1});
    end
    total++;
    if ({addra, ioa, rda} !== 24'h0) begin
      bad++; $display("FAIL reset_data: got %h want 000000", {addra, ioa, rda});
    end
    rst_n = 1'b1;
    v0 = 1'b1; v1 = 1'b1; #1;
    total++;
    if ({ra0, ra1} !== 2'b10) begin
      bad++; $display("FAIL reset_rr_pref: got %b want 10", {ra0, ra1});
    end
    v0 = 1'b0; #1;
    total++;
    if ({ra0, ra1} !== 2'b01) begin
      bad++; $display("FAIL single_p1_ready: got %b want 01", {ra0, ra1});
    end
    v1 = 1'b0;
  endtask

  task automatic test_write_read();
    int lat, wl, ol, aw;
    logic [7:0] rd;
    use6 = 1'b0;
    do_access(1'b0, 1'b1, 8'h3C, 8'hA5, lat, rd, wl, ol, aw);
    total++; if (lat !== 4) begin bad++; $display("FAIL t1_wr_lat: got %0d want 4", lat); end
    total++; if (wl !== 2)  begin bad++; $display("FAIL t1_we_low: got %0d want 2", wl); end
    total++; if (ol !== 0)  begin bad++; $display("FAIL t1_wr_oe_low: got %0d want 0", ol); end
    v0 = 1'b1; we0 = 1'b0; a0 = 8'h3C; #1;
    total++; if ({ra0, busya} !== 2'b01) begin bad++; $display("FAIL t1_busy_hold: got %b want 01", {ra0, busya}); end
    do_access(1'b0, 1'b0, 8'h3C, 8'h00, lat, rd, wl, ol, aw);
    total++; if (aw !== 0)     begin bad++; $display("FAIL t1_next_accept: got %0d want 0", aw); end
    total++; if (lat !== 4)    begin bad++; $display("FAIL t1_rd_lat: got %0d want 4", lat); end
    total++; if (ol !== 2)     begin bad++; $display("FAIL t1_oe_low: got %0d want 2", ol); end
    total++; if (rd !== 8'hA5) begin bad++; $display("FAIL t1_rdata: got %h want a5", rd); end
  endtask

  task automatic test_simultaneous();
    int lat, wl, ol, aw;
    logic [7:0] rd;
    use6 = 1'b0;
    apply_reset();
    run_pair(1, 1, 8'h10, 8'h11, 8'h20, 8'h22);
    total++; if (ng !== 2 || nd !== 2) begin bad++; $display("FAIL t2_counts: got %0d/%0d want 2/2", ng, nd); end
    total++; if ({grants[0], grants[1]} !== 2'b01) begin bad++; $display("FAIL t2_grants: got %b want 01", {grants[0], grants[1]}); end
    total++; if ({dones[0], dones[1]} !== 2'b01) begin bad++; $display("FAIL t2_dones: got %b want 01", {dones[0], dones[1]}); end
    do_access(1'b0, 1'b0, 8'h10, 8'h00, lat, rd, wl, ol, aw);
    total++; if (rd !== 8'h11 || lat !== 4) begin bad++; $display("FAIL t2_rd10: got %h/%0d want 11/4", rd, lat); end
    do_access(1'b1, 1'b0, 8'h20, 8'h00, lat, rd, wl, ol, aw);
    total++; if (rd !== 8'h22 || lat !== 4) begin bad++; $display("FAIL t2_rd20: got %h/%0d want 22/4", rd, lat); end
  endtask

  task automatic test_fairness();
    int lat, wl, ol, aw;
    logic [7:0] rd;
    use6 = 1'b0;
    apply_reset();
    run_pair(3, 3, 8'h40, 8'h50, 8'h60, 8'h70);
    total++; if (ng !== 6 || nd !== 6) begin bad++; $display("FAIL t3_counts: got %0d/%0d want 6/6", ng, nd); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (grants[i] !== 1'(i % 2)) begin bad++; $display("FAIL t3_grant%0d: got %b want %0d", i, grants[i], i % 2); end
      total++;
      if (dones[i] !== 1'(i % 2)) begin bad++; $display("FAIL t3_done%0d: got %b want %0d", i, dones[i], i % 2); end
    end
    do_access(1'b1, 1'b0, 8'h62, 8'h00, lat, rd, wl, ol, aw);
    total++; if (rd !== 8'h72) begin bad++; $display("FAIL t3_rd62: got %h want 72", rd); end
  endtask

  task automatic test_bus_safety();
    logic [7:0] refm [16];
    logic       refv [16];
    logic       acc0f = 1'b0, acc1f = 1'b0;
    logic       pw = 1'b1, pport = 1'b0, pknown = 1'b0;
    logic [7:0] pexp = '0;
    for (int i = 0; i < 16; i++) refv[i] = 1'b0;
    use6 = 1'b0;
    apply_reset();
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (!v0 || acc0f) begin
        v0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
        a0 = 8'($urandom_range(0, 15)); d0 = 8'($urandom);
      end
      if (!v1 || acc1f) begin
        v1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
        a1 = 8'($urandom_range(0, 15)); d1 = 8'($urandom);
      end
      acc0f = 1'b0; acc1f = 1'b0;
      #1;
      total++;
      if ((ioea & ~oea) || ((~wea | ~oea) & csa)) begin
        bad++; $display("FAIL t4_bus_a: cycle %0d io_oe=%b oe_b=%b we_b=%b cs_b=%b", c, ioea, oea, wea, csa);
      end
      total++;
      if ((ioeb & ~oeb) || ((~web | ~oeb) & csb)) begin
        bad++; $display("FAIL t4_bus_b: cycle %0d io_oe=%b oe_b=%b we_b=%b cs_b=%b", c, ioeb, oeb, web, csb);
      end
      if (da0 || da1) begin
        total++;
        if ({da0, da1} !== (pport ? 2'b01 : 2'b10)) begin
          bad++; $display("FAIL t4_done_port: got %b want port %0d", {da0, da1}, pport);
        end
        if (!pw && pknown) begin
          total++;
          if (rda !== pexp) begin bad++; $display("FAIL t4_rdata: got %h want %h", rda, pexp); end
        end
      end
      if (v0 && ra0) begin
        acc0f = 1'b1; pport = 1'b0; pw = we0;
        pexp = refm[a0[3:0]]; pknown = refv[a0[3:0]];
        if (we0) begin refm[a0[3:0]] = d0; refv[a0[3:0]] = 1'b1; end
      end else if (v1 && ra1) begin
        acc1f = 1'b1; pport = 1'b1; pw = we1;
        pexp = refm[a1[3:0]]; pknown = refv[a1[3:0]];
        if (we1) begin refm[a1[3:0]] = d1; refv[a1[3:0]] = 1'b1; end
      end
    end
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int lat, wl, ol, aw, quiet;
    logic [7:0] rd;
    use6 = 1'b0;
    apply_reset();
    do_access(1'b0, 1'b1, 8'h07, 8'h5A, lat, rd, wl, ol, aw);
    @(negedge clk);
    v0 = 1'b1; we0 = 1'b1; a0 = 8'h05; d0 = 8'hC3; #1;
    total++; if (ra0 !== 1'b1) begin bad++; $display("FAIL t5_accept: got %b want 1", ra0); end
    @(negedge clk); v0 = 1'b0;
    @(negedge clk); #1;
    total++; if (wea !== 1'b0) begin bad++; $display("FAIL t5_in_wr_low: got %b want 0", wea); end
    rst_n = 1'b0;
    @(negedge clk); #1;
    total++;
    if ({csa, wea, oea, ioea, busya, da0} !== 6'b111000) begin
      bad++; $display("FAIL t5_abort: got %b want 111000", {csa, wea, oea, ioea, busya, da0});
    end
    rst_n = 1'b1;
    quiet = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (!da0 && !da1) quiet++;
    end
    total++; if (quiet !== 4) begin bad++; $display("FAIL t5_no_done: got %0d quiet cycles want 4", quiet); end
    do_access(1'b0, 1'b0, 8'h07, 8'h00, lat, rd, wl, ol, aw);
    total++; if (rd !== 8'h5A || lat !== 4) begin bad++; $display("FAIL t5_read07: got %h/%0d want 5a/4", rd, lat); end
  endtask

  task automatic test_params();
    int lat, wl, ol, aw;
    logic [7:0] rd;
    use6 = 1'b1;
    apply_reset();
    do_access(1'b0, 1'b1, 8'h33, 8'h96, lat, rd, wl, ol, aw);
    total++; if (lat !== 3) begin bad++; $display("FAIL t6_wr_lat: got %0d want 3", lat); end
    total++; if (wl !== 1)  begin bad++; $display("FAIL t6_we_low: got %0d want 1", wl); end
    do_access(1'b1, 1'b0, 8'h33, 8'h00, lat, rd, wl, ol, aw);
    total++; if (lat !== 6)    begin bad++; $display("FAIL t6_rd_lat: got %0d want 6", lat); end
    total++; if (ol !== 4)     begin bad++; $display("FAIL t6_oe_low: got %0d want 4", ol); end
    total++; if (rd !== 8'h96) begin bad++; $display("FAIL t6_rdata: got %h want 96", rd); end
    use6 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_simultaneous();
    test_fairness();
    test_bus_safety();
    test_reset_mid_write();
    test_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
